// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle integer ALU with optional iterative multiply/divide
//
// Purpose: executes base integer ops in one cycle; with ALU_MC_MULDIV_EN
// defined, also executes multiply/divide/remainder iteratively over WIDTH
// cycles behind a valid/ready handshake. Result is registered with flags.
//
// Configuration macro: ALU_MC_MULDIV_EN (undefined: m_ext ops return 0 in
// one cycle and in_ready is constant 1).
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous, active-high
//   in_valid  - operation request
//   in_ready  - block can accept (registered, high in IDLE only)
//   in1, in2  - operands
//   control   - base op select; funct3 in control[2:0] when m_ext=1
//   m_ext     - selects the multiply/divide group
//   out_valid - one-cycle pulse, result valid
//   out       - result, held until the next result
//   zero      - out == 0
//   neg       - out[WIDTH-1]
module alu_mc #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [3:0]       control,
  input  logic             m_ext,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             neg
);

  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] base_res;
  logic [SHW-1:0]   shamt;

  assign shamt = in2[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (control)
      4'd0:       base_res = in1 + in2;
      4'd8, 4'd9: base_res = in1 - in2;
      4'd1:       base_res = in1 << shamt;
      4'd2:       base_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
      4'd3:       base_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
      4'd4:       base_res = in1 ^ in2;
      4'd5:       base_res = in1 >> shamt;
      4'd13:      base_res = $signed(in1) >>> shamt;
      4'd6:       base_res = in1 | in2;
      4'd7:       base_res = in1 & in2;
      default:    base_res = '0;
    endcase
  end

`ifdef ALU_MC_MULDIV_EN
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;     // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] opnd_q, opnd_d; // multiplicand / divisor magnitude
  logic [2:0]       op_q, op_d;
  logic             sgn_q, sgn_d;   // result must be negated at the end
  logic             dz_q, dz_d;     // divide by zero seen at accept

  logic             a_sgn, b_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] mul_add, div_diff, acc_nx, lo_nx, quo, rem, m_res;
  logic [WIDTH:0]   mul_sum, div_sh;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod, prod_s;

  // mul (0) is treated as signed x signed; its low half is sign-agnostic.
  assign a_sgn = control[2] ? ~control[0] : (control[1:0] != 2'b11);
  assign b_sgn = control[2] ? ~control[0] : ~control[1];
  assign a_neg = a_sgn & in1[WIDTH-1];
  assign b_neg = b_sgn & in2[WIDTH-1];
  assign a_mag = a_neg ? -in1 : in1;
  assign b_mag = b_neg ? -in2 : in2;

  always_comb begin
    mul_add  = lo_q[0] ? opnd_q : '0;
    mul_sum  = {1'b0, acc_q} + {1'b0, mul_add};
    div_sh   = {acc_q, lo_q[WIDTH-1]};
    div_ge   = (div_sh >= {1'b0, opnd_q});
    // Only used when div_ge, where the true difference fits in WIDTH bits.
    div_diff = div_sh[WIDTH-1:0] - opnd_q;
    if (op_q[2]) begin
      acc_nx = div_ge ? div_diff : div_sh[WIDTH-1:0];
      lo_nx  = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      acc_nx = mul_sum[WIDTH:1];
      lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
    prod   = {acc_nx, lo_nx};
    prod_s = sgn_q ? -prod : prod;
    quo    = dz_q ? '1 : (sgn_q ? -lo_nx : lo_nx);
    rem    = sgn_q ? -acc_nx : acc_nx;
    case (op_q)
      3'd0:             m_res = prod_s[WIDTH-1:0];
      3'd1, 3'd2, 3'd3: m_res = prod_s[2*WIDTH-1:WIDTH];
      3'd4, 3'd5:       m_res = quo;
      default:          m_res = rem;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    lo_d        = lo_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    sgn_d       = sgn_q;
    dz_d        = dz_q;
    res_d       = res_q;
    out_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (m_ext) begin
            state_d = S_BUSY;
            cnt_d   = '0;
            acc_d   = '0;
            op_d    = control[2:0];
            sgn_d   = (control[2] & control[1]) ? a_neg : (a_neg ^ b_neg);
            dz_d    = control[2] & (in2 == '0);
            lo_d    = control[2] ? a_mag : b_mag;
            opnd_d  = control[2] ? b_mag : a_mag;
          end else begin
            res_d       = base_res;
            out_valid_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_d = acc_nx;
        lo_d  = lo_nx;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d     = S_IDLE;
          res_d       = m_res;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      sgn_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      sgn_q   <= sgn_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
`else
  always_comb begin
    res_d       = res_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      res_d       = m_ext ? '0 : base_res;
      out_valid_d = 1'b1;
    end
  end

  assign in_ready = 1'b1;
`endif

  assign zero_d = (res_d == '0);
  assign neg_d  = res_d[WIDTH-1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q       <= '0;
      zero_q      <= 1'b1;
      neg_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      res_q       <= res_d;
      zero_q      <= zero_d;
      neg_q       <= neg_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out       = res_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc
module tb_alu_mc;
  localparam int W = 32;
`ifdef ALU_MC_MULDIV_EN
  localparam int MLAT = W;
`else
  localparam int MLAT = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          m_ext = 1'b0;
  logic [3:0]    control = 4'd0;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic          in_ready, out_valid, zero, neg;
  logic [W-1:0]  out;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] v;
    int          due;
  } exp_t;
  exp_t q[$];

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .control(control), .m_ext(m_ext),
    .out_valid(out_valid), .out(out), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour from the operation definitions, using 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [3:0] c, input logic m,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    logic [63:0] ua, ub, up;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    r  = '0;
    if (m) begin
`ifdef ALU_MC_MULDIV_EN
      case (c[2:0])
        3'd0: begin p = sa * sb; r = p[31:0]; end
        3'd1: begin p = sa * sb; r = p[63:32]; end
        3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
        3'd3: begin up = ua * ub; r = up[63:32]; end
        3'd4: begin
          if (b == 0) r = 32'hFFFFFFFF;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 32'h80000000;
          else begin p = sa / sb; r = p[31:0]; end
        end
        3'd5: r = (b == 0) ? 32'hFFFFFFFF : a / b;
        3'd6: begin
          if (b == 0) r = a;
          else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = 0;
          else begin p = sa % sb; r = p[31:0]; end
        end
        default: r = (b == 0) ? a : a % b;
      endcase
`else
      r = '0;
`endif
    end else begin
      case (c)
        4'd0:       r = a + b;
        4'd8, 4'd9: r = a - b;
        4'd1:       begin up = ua << b[4:0]; r = up[31:0]; end
        4'd2:       r = (sa < sb) ? 32'd1 : 32'd0;
        4'd3:       r = (ua < ub) ? 32'd1 : 32'd0;
        4'd4:       r = a ^ b;
        4'd5:       r = a >> b[4:0];
        4'd13:      begin p = sa >>> b[4:0]; r = p[31:0]; end
        4'd6:       r = a | b;
        4'd7:       r = a & b;
        default:    r = '0;
      endcase
    end
    return r;
  endfunction

  // Checks every result pulse against the expectation queue, including its cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", {63'b0, out_valid}, 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("latency_cycle", cyc, e.due);
          chk("out", out, e.v);
          chk("zero", zero, (e.v == 0));
          chk("neg", neg, e.v[31]);
        end
      end else if (q.size() > 0 && cyc > q[0].due) begin
        chk("missing_out_valid", {63'b0, out_valid}, 64'd1);
        void'(q.pop_front());
      end
    end
  end

`ifndef ALU_MC_MULDIV_EN
  always @(negedge clk) begin
    if (!reset && !in_ready) chk("in_ready_constant", {63'b0, in_ready}, 64'd1);
  end
`endif

  // Called at a negedge; drives one request for one cycle.
  task automatic issue(input logic [3:0] c, input logic m, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    control  = c;
    m_ext    = m;
    in1      = a;
    in2      = b;
    in_valid = 1'b1;
    chk("in_ready_at_issue", {63'b0, in_ready}, 64'd1);
    e.v   = model(c, m, a, b);
    e.due = cyc + 1 + (m ? MLAT : 0);
    q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    in1      = $urandom;
    in2      = $urandom;
    control  = 4'($urandom);
    m_ext    = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (q.size() == 0) break;
      @(negedge clk);
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic run1(input string name, input logic [3:0] c, input logic m,
                      input logic [31:0] a, input logic [31:0] b, input logic [31:0] lit);
    issue(c, m, a, b);
    drain();
    chk(name, out, lit);
  endtask

  logic [3:0]  bc [12] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd15, 4'd13};
  logic [31:0] ba [12] = '{32'h1, 32'hF0F0F0F0, 32'hFFFFFFFE, 32'h5, 32'hA5A5A5A5, 32'h80000000,
                           32'h0F00, 32'hFF00FF00, 32'h3, 32'h1234, 32'hFFFF, 32'h7FFFFFF0};
  logic [31:0] bb [12] = '{32'd31, 32'h24, 32'h1, 32'hFFFFFFFF, 32'h5A5A5A5A, 32'd36,
                           32'h00F0, 32'h0FF00FF0, 32'h5, 32'h1, 32'h1, 32'd4};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    // Hand-computed pins on the reference model.
    chk("pin_add", model(4'd0, 1'b0, 32'h7FFFFFFF, 32'h1), 32'h80000000);
    chk("pin_sra", model(4'd13, 1'b0, 32'h80000000, 32'd4), 32'hF8000000);
    chk("pin_sltu", model(4'd3, 1'b0, 32'h1, 32'hFFFFFFFF), 32'h1);
    chk("pin_slt", model(4'd2, 1'b0, 32'hFFFFFFFF, 32'h1), 32'h1);
`ifdef ALU_MC_MULDIV_EN
    chk("pin_mulhu", model(4'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFE);
    chk("pin_mulhsu", model(4'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF), 32'hFFFFFFFF);
    chk("pin_div_neg", model(4'd4, 1'b1, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFD);
    chk("pin_rem_neg", model(4'd6, 1'b1, 32'hFFFFFFF9, 32'd2), 32'hFFFFFFFF);
`else
    chk("pin_mul_off", model(4'd0, 1'b1, 32'd3, 32'd4), 32'h0);
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_zero", {63'b0, zero}, 1);
    chk("rst_neg", {63'b0, neg}, 0);
    chk("rst_out_valid", {63'b0, out_valid}, 0);
    chk("rst_in_ready", {63'b0, in_ready}, 1);
    reset = 1'b0;
    @(negedge clk);

    run1("add_overflow", 4'd0, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h80000000);
    chk("add_overflow_neg", {63'b0, neg}, 1);
    chk("add_overflow_zero", {63'b0, zero}, 0);

    issue(4'd8, 1'b0, 32'd5, 32'd5);
    issue(4'd13, 1'b0, 32'h80000000, 32'd4);
    issue(4'd3, 1'b0, 32'h1, 32'hFFFFFFFF);
    drain();
    chk("b2b_sltu", out, 32'h1);

    for (int i = 0; i < 12; i++) issue(bc[i], 1'b0, ba[i], bb[i]);
    drain();

`ifdef ALU_MC_MULDIV_EN
    issue(4'd1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    // Requests while busy must be ignored and in_ready must stay low.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      m_ext    = 1'b0;
      control  = 4'd0;
      in1      = 32'd9;
      chk("busy_in_ready", {63'b0, in_ready}, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    drain();
    chk("mulh_m1_m1", out, 32'h0);
    run1("mulhu_ff_ff", 4'd3, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    run1("div_ovf", 4'd4, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run1("rem_ovf", 4'd6, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h0);
    run1("divu_by0", 4'd5, 1'b1, 32'd7, 32'd0, 32'hFFFFFFFF);
    run1("remu_by0", 4'd7, 1'b1, 32'd7, 32'd0, 32'd7);
    run1("mul_3x4", 4'd0, 1'b1, 32'd3, 32'd4, 32'd12);
    issue(4'd0, 1'b1, 32'hFFFFFFFD, 32'd5);
    issue(4'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(4'd4, 1'b1, 32'hFFFFFFF9, 32'd2);
    issue(4'd6, 1'b1, 32'hFFFFFFF9, 32'd2);
    issue(4'd4, 1'b1, 32'hFFFFFFF9, 32'd0);
    issue(4'd6, 1'b1, 32'hFFFFFFF9, 32'd0);
    issue(4'd5, 1'b1, 32'hDEADBEEF, 32'h1234);
    issue(4'd7, 1'b1, 32'hDEADBEEF, 32'h1234);
    issue(4'd1, 1'b1, 32'h7FFFFFFF, 32'h80000000);
    drain();
`else
    run1("mul_off_3x4", 4'd0, 1'b1, 32'd3, 32'd4, 32'h0);
    chk("mul_off_zero", {63'b0, zero}, 1);
    issue(4'd4, 1'b1, 32'd100, 32'd7);
    issue(4'd0, 1'b0, 32'd10, 32'd20);
    drain();
`endif

    // Reset ten cycles into a divide aborts it.
    issue(4'd4, 1'b1, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_out", out, 0);
    chk("abort_zero", {63'b0, zero}, 1);
    chk("abort_in_ready", {63'b0, in_ready}, 1);
    chk("abort_out_valid", {63'b0, out_valid}, 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    run1("after_abort_add", 4'd0, 1'b0, 32'd2, 32'd3, 32'd5);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
